// File: rtl/iob_cache_req_pipe_pkg.sv
// Shared cache-front-end widths and helpers for the request pipe and its FIFO.
package iob_cache_req_pipe_pkg;

  // Front-end byte-address width, data width and queue depth exponent.
  localparam int CACHE_ADDR_W  = 32;
  localparam int CACHE_DATA_W  = 32;
  localparam int CACHE_DEPTH_W = 2;

  // Queue operation selected in a cycle, encoded as {push, pop}.
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/iob_cache_req_fifo.sv
// Synchronous request FIFO with a flush that keeps only the head entry.
module iob_cache_req_fifo
  import iob_cache_req_pipe_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH_W = CACHE_DEPTH_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [WIDTH-1:0]   head_data,
  output logic [DEPTH_W:0]   count,
  output logic               full,
  output logic               empty
);

  localparam int DEPTH = 2 ** DEPTH_W;
  localparam logic [DEPTH_W:0]   CNT_FULL = (DEPTH_W + 1)'(DEPTH);
  localparam logic [DEPTH_W:0]   CNT_ONE  = (DEPTH_W + 1)'(1);
  localparam logic [DEPTH_W-1:0] PTR_ONE  = DEPTH_W'(1);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W-1:0] rd_ptr;
  logic               push_en;
  logic               pop_en;
  fifo_op_e           op;

  // A push is refused when full or during a flush; a pop needs a head entry.
  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign push_en   = push & ~full & ~flush;
  assign pop_en    = pop & ~empty;
  assign op        = fifo_op_e'({push_en, pop_en});
  assign head_data = mem[rd_ptr];

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy update; flush rewinds the write pointer to just past the head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      if (!empty) begin
        wr_ptr <= rd_ptr + PTR_ONE;
        rd_ptr <= pop_en ? rd_ptr + PTR_ONE : rd_ptr;
        count  <= pop_en ? '0 : CNT_ONE;
      end
    end else begin
      case (op)
        FIFO_PUSH: begin
          wr_ptr <= wr_ptr + PTR_ONE;
          count  <= count + CNT_ONE;
        end
        FIFO_POP: begin
          rd_ptr <= rd_ptr + PTR_ONE;
          count  <= count - CNT_ONE;
        end
        FIFO_BOTH: begin
          wr_ptr <= wr_ptr + PTR_ONE;
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/iob_cache_req_pipe.sv
// Request queue between a CPU front end and the native cache port.
// Requests are queued, presented in order with a valid/ready handshake,
// completed combinationally and counted while the cache stalls.
module iob_cache_req_pipe
  import iob_cache_req_pipe_pkg::*;
#(
  parameter int FE_ADDR_W = CACHE_ADDR_W,
  parameter int FE_DATA_W = CACHE_DATA_W,
  parameter int DEPTH_W   = CACHE_DEPTH_W
) (
  input  logic                                        clk,
  input  logic                                        reset,
  // CPU request side
  input  logic                                        req_valid,
  output logic                                        req_ready,
  input  logic [FE_ADDR_W-$clog2(FE_DATA_W/8)-1:0]    req_addr,
  input  logic [FE_DATA_W-1:0]                        req_wdata,
  input  logic [FE_DATA_W/8-1:0]                      req_wstrb,
  input  logic                                        flush,
  // Cache native side
  output logic                                        valid,
  output logic [FE_ADDR_W-$clog2(FE_DATA_W/8)-1:0]    addr,
  output logic [FE_DATA_W-1:0]                        wdata,
  output logic [FE_DATA_W/8-1:0]                      wstrb,
  input  logic [FE_DATA_W-1:0]                        rdata,
  input  logic                                        ready,
  // Completion side
  output logic                                        resp_valid,
  output logic                                        resp_we,
  output logic [FE_DATA_W-1:0]                        resp_rdata,
  // Status
  output logic [DEPTH_W:0]                            level,
  output logic [31:0]                                 stall_cnt
);

  localparam int REQ_ADDR_W = FE_ADDR_W - $clog2(FE_DATA_W / 8);
  localparam int STRB_W     = FE_DATA_W / 8;
  localparam int ENTRY_W    = REQ_ADDR_W + FE_DATA_W + STRB_W;

  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [DEPTH_W:0]   count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  // Accept only while not full; a pop in the same cycle does not open a slot.
  assign req_ready  = ~full;
  assign push       = req_valid & req_ready;
  assign push_entry = {req_addr, req_wdata, req_wstrb};

  // The head is presented straight from storage, so it stays put until popped.
  assign valid = ~empty;
  assign {addr, wdata, wstrb} = head_entry;
  assign pop   = valid & ready;
  assign level = count;

  // Completion is the handshake cycle itself, with read data passed through.
  assign resp_valid = pop;
  assign resp_we    = pop & (|wstrb);
  assign resp_rdata = rdata;

  iob_cache_req_fifo #(
    .WIDTH   (ENTRY_W),
    .DEPTH_W (DEPTH_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .head_data (head_entry),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Count cycles where the cache holds off a presented request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (valid && !ready) begin
      stall_cnt <= sat_inc32(stall_cnt);
    end
  end

endmodule

// File: tb/tb_iob_cache_req_pipe.sv
// Directed bench for iob_cache_req_pipe with a queue-based reference model.
module tb_iob_cache_req_pipe;

  localparam int FE_ADDR_W = 32;
  localparam int FE_DATA_W = 32;
  localparam int DEPTH_W   = 2;
  localparam int A_W       = 30;
  localparam int S_W       = 4;
  localparam int DEPTH     = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [A_W-1:0] req_addr = '0;
  logic [31:0]    req_wdata = '0;
  logic [S_W-1:0] req_wstrb = '0;
  logic           flush = 1'b0;
  logic           valid;
  logic [A_W-1:0] addr;
  logic [31:0]    wdata;
  logic [S_W-1:0] wstrb;
  logic [31:0]    rdata = '0;
  logic           ready = 1'b0;
  logic           resp_valid;
  logic           resp_we;
  logic [31:0]    resp_rdata;
  logic [DEPTH_W:0] level;
  logic [31:0]    stall_cnt;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  typedef struct {
    logic [A_W-1:0] addr;
    logic [31:0]    wdata;
    logic [S_W-1:0] wstrb;
  } req_t;

  req_t           q[$];
  logic [31:0]    m_stall = '0;
  logic [A_W-1:0] done_addr[$];

  always #5 clk = ~clk;

  iob_cache_req_pipe #(
    .FE_ADDR_W (FE_ADDR_W),
    .FE_DATA_W (FE_DATA_W),
    .DEPTH_W   (DEPTH_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .flush      (flush),
    .valid      (valid),
    .addr       (addr),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .rdata      (rdata),
    .ready      (ready),
    .resp_valid (resp_valid),
    .resp_we    (resp_we),
    .resp_rdata (resp_rdata),
    .level      (level),
    .stall_cnt  (stall_cnt)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [A_W-1:0] ad(input int v);
    return A_W'(v);
  endfunction

  // Reference model: an ordered list of pending requests, advanced on each clock.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_stall = '0;
    end else begin
      bit   has_head;
      bit   do_pop;
      bit   do_push;
      req_t h;
      req_t n;
      has_head = (q.size() > 0);
      do_pop   = has_head && ready;
      do_push  = req_valid && (q.size() < DEPTH);
      if (has_head && !ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (flush) begin
        if (has_head) begin
          h = q[0];
          q.delete();
          if (!do_pop) q.push_back(h);
        end
      end else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          n.addr  = req_addr;
          n.wdata = req_wdata;
          n.wstrb = req_wstrb;
          q.push_back(n);
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always begin
    @(negedge clk);
    #2;
    if (check_en) begin
      checkOutput("level", 64'(level), 64'(q.size()));
      checkOutput("req_ready", 64'(req_ready), 64'(q.size() < DEPTH));
      checkOutput("valid", 64'(valid), 64'(q.size() > 0));
      checkOutput("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      checkOutput("resp_valid", 64'(resp_valid), 64'((q.size() > 0) && ready));
      if (q.size() > 0) begin
        checkOutput("addr", 64'(addr), 64'(q[0].addr));
        checkOutput("wdata", 64'(wdata), 64'(q[0].wdata));
        checkOutput("wstrb", 64'(wstrb), 64'(q[0].wstrb));
        if (ready) begin
          checkOutput("resp_we", 64'(resp_we), 64'(|q[0].wstrb));
          checkOutput("resp_rdata", 64'(resp_rdata), 64'(rdata));
        end
      end
      if (resp_valid) done_addr.push_back(addr);
    end
  end

  task automatic applyStimulus(input logic rst, input logic rv, input logic [A_W-1:0] a,
                               input logic [31:0] d, input logic [S_W-1:0] s,
                               input logic rdy, input logic [31:0] rd, input logic fl);
    @(negedge clk);
    reset     = rst;
    req_valid = rv;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    ready     = rdy;
    rdata     = rd;
    flush     = fl;
  endtask

  task automatic idle(input int n, input logic rdy, input logic [31:0] rd);
    repeat (n) applyStimulus(1'b1, 1'b0, '0, '0, '0, rdy, rd, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    done_addr.delete();
  endtask

  task automatic checkDone(input int base, input int n);
    checkOutput("done_count", 64'(done_addr.size()), 64'(n));
    for (int k = 0; k < n; k++) begin
      if (k < done_addr.size()) checkOutput("done_order", 64'(done_addr[k]), 64'(base + k));
    end
  endtask

  initial begin
    // Reset state, with ready high to show it is ignored while empty
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 32'h1111, 1'b0);
    check_en = 1'b1;
    #3;
    checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_valid", 64'(valid), 64'd0);
    checkOutput("rst_level", 64'(level), 64'd0);
    checkOutput("rst_stall", 64'(stall_cnt), 64'd0);
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1, 32'h1111, 1'b0);
    done_addr.delete();

    // Back-to-back writes with the cache always ready
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, ad(i), 32'(i), 4'hF, 1'b1, '0, 1'b0);
      if (i == 1) begin
        #3;
        checkOutput("b2b_first_valid", 64'(valid), 64'd1);
        checkOutput("b2b_first_addr", 64'(addr), 64'd0);
        checkOutput("b2b_first_we", 64'(resp_we), 64'd1);
      end
    end
    idle(3, 1'b1, '0);
    #3;
    checkDone(0, 10);
    checkOutput("b2b_stall", 64'(stall_cnt), 64'd0);

    // Fill to full with the cache stalled, then drain in order
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, ad(32'h100 + i), 32'hA0 + 32'(i), 4'h1, 1'b0, '0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    #3;
    checkOutput("fill_level", 64'(level), 64'd4);
    checkOutput("fill_req_ready", 64'(req_ready), 64'd0);
    applyStimulus(1'b1, 1'b1, ad(32'h1FF), 32'hFF, 4'h1, 1'b1, 32'h1234, 1'b0);
    #3;
    checkOutput("fill_pop_full_ready", 64'(req_ready), 64'd0);
    checkOutput("fill_pop_resp", 64'(resp_valid), 64'd1);
    idle(4, 1'b1, 32'h5678);
    #3;
    checkOutput("drain_level", 64'(level), 64'd0);
    checkOutput("drain_req_ready", 64'(req_ready), 64'd1);
    checkDone(32'h100, 4);

    // Read held under a seven-cycle stall
    doReset();
    applyStimulus(1'b1, 1'b1, ad(32'h10), '0, 4'h0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
      #3;
      checkOutput("stall_addr", 64'(addr), 64'h10);
      checkOutput("stall_wstrb", 64'(wstrb), 64'd0);
    end
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1, 32'hDEAD, 1'b0);
    #3;
    checkOutput("stall_resp_valid", 64'(resp_valid), 64'd1);
    checkOutput("stall_rdata", 64'(resp_rdata), 64'hDEAD);
    checkOutput("stall_resp_we", 64'(resp_we), 64'd0);
    checkOutput("stall_count", 64'(stall_cnt), 64'd7);
    idle(1, 1'b1, '0);

    // Flush keeps only the in-flight head
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, ad(32'h20 + i), 32'h200 + 32'(i), 4'hF, 1'b0, '0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    #3;
    checkOutput("flush_pre_level", 64'(level), 64'd3);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    #3;
    checkOutput("flush_level", 64'(level), 64'd1);
    checkOutput("flush_head", 64'(addr), 64'h20);
    idle(2, 1'b1, '0);
    applyStimulus(1'b1, 1'b1, ad(32'h30), 32'h300, 4'h3, 1'b1, '0, 1'b0);
    applyStimulus(1'b1, 1'b1, ad(32'h31), 32'h301, 4'h0, 1'b1, '0, 1'b0);
    idle(3, 1'b1, '0);
    #3;
    checkOutput("flush_done_count", 64'(done_addr.size()), 64'd3);
    if (done_addr.size() == 3) begin
      checkOutput("flush_done0", 64'(done_addr[0]), 64'h20);
      checkOutput("flush_done1", 64'(done_addr[1]), 64'h30);
      checkOutput("flush_done2", 64'(done_addr[2]), 64'h31);
    end
    applyStimulus(1'b1, 1'b1, ad(32'h40), 32'h400, 4'hF, 1'b0, '0, 1'b1);
    #3;
    checkOutput("flush_empty_ready", 64'(req_ready), 64'd1);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    #3;
    checkOutput("flush_empty_level", 64'(level), 64'd0);
    checkOutput("flush_empty_valid", 64'(valid), 64'd0);
    applyStimulus(1'b1, 1'b1, ad(32'h41), 32'h410, 4'hF, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b1, ad(32'h42), 32'h420, 4'hF, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    #3;
    checkOutput("flush_pop_level", 64'(level), 64'd0);
    checkOutput("flush_pop_last", 64'(done_addr[done_addr.size()-1]), 64'h41);

    // Steady push+pop at level 3 across pointer wrap
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, ad(32'h50 + i), 32'h500 + 32'(i), 4'h0, 1'b0, '0, 1'b0);
    end
    for (int i = 3; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, ad(32'h50 + i), 32'h500 + 32'(i), 4'h0, 1'b1, 32'hC0 + 32'(i), 1'b0);
      #3;
      checkOutput("pp_level", 64'(level), 64'd3);
    end
    idle(4, 1'b1, '0);
    #3;
    checkDone(32'h50, 20);

    // Reset in the middle of a stalled burst
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, ad(32'h60 + i), 32'h600 + 32'(i), 4'hF, 1'b0, '0, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    #3;
    checkOutput("midrst_valid", 64'(valid), 64'd0);
    checkOutput("midrst_level", 64'(level), 64'd0);
    checkOutput("midrst_req_ready", 64'(req_ready), 64'd1);
    applyStimulus(1'b1, 1'b1, ad(32'h70), 32'h77, 4'hF, 1'b0, '0, 1'b0);
    #3;
    checkOutput("postrst_valid0", 64'(valid), 64'd0);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    #3;
    checkOutput("postrst_valid1", 64'(valid), 64'd1);
    checkOutput("postrst_addr", 64'(addr), 64'h70);
    idle(2, 1'b1, '0);

    #10;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
